// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked adder slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Chunk counter width; never narrower than one bit so single-pass builds still elaborate.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell used as the ripple element of chunk_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice per clock through a single shared
// ripple adder, with the inter-chunk carry held in a register.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1) begin : g_chunk_err
    $error("chunked_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_width_err
    $error("chunked_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  int               base;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry),
    .s   (s_chunk),
    .cout(c_chunk)
  );

  // sum_next is the result register with the current chunk spliced in, so the flags on the
  // last chunk see the complete sum rather than the stale top slice.
  always_comb begin
    base     = int'(cnt) * CHUNK;
    a_chunk  = a_r[base +: CHUNK];
    b_chunk  = b_r[base +: CHUNK];
    sum_next = sum_r;
    sum_next[base +: CHUNK] = s_chunk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= c_chunk;
          if (cnt == LAST) begin
            cnt    <= '0;
            cout_r <= c_chunk;
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_next[WIDTH-1] != a_r[WIDTH-1]);
            zero_r <= (sum_next == '0);
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; results hold until taken.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: a 32/8 instance for directed and random ops, and a 16/16
// single-pass instance for a random stream with output stalls.
module tb_chunked_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0, zero0;
  logic [31:0] a0, b0, sum0;
  logic [1:0]  dbg0;

  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, zero1;
  logic [15:0] a1, b1, sum1;
  logic [1:0]  dbg1;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0), .dbg_state(dbg0)
  );

  chunked_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1), .dbg_state(dbg1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t        vecs[12];
  int          checks;
  int          errors;
  logic [18:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: modular sum in wide arithmetic, overflow as "signed result out of range".
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                    input logic sub, input int w, output logic [31:0] s,
                                    output logic c, output logic ov, output logic z);
    longint unsigned mask, be, t;
    longint sa, sb, r, lim;
    mask = (64'd1 << w) - 64'd1;
    be   = 64'(b) & mask;
    if (sub) be = ~be & mask;
    t  = (64'(a) & mask) + be + 64'(cin);
    s  = 32'(t & mask);
    c  = t[w];
    sa = longint'(64'(a) & mask);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    sb = longint'(be);
    if (be[w-1]) sb = sb - (longint'(1) << w);
    r   = sa + sb + longint'(cin);
    lim = longint'(1) << (w - 1);
    ov  = (r >= lim) || (r < -lim);
    z   = (s == 32'd0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers for dut0 (called at a negedge) ----------------
  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                       output int lat);
    int guard;
    a0 = a; b0 = b; cin0 = c; sub0 = s; in_valid0 = 1'b1;
    guard = 0;
    while (!in_ready0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("dut0_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid0 = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain0();
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int          lat;
    int          g;
    logic [31:0] ra, rb, rs;
    logic        rcin, rsub, rc, rov, rz;

    checks = 0;
    errors = 0;
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0, 32'h1234_567A, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

    // clock/reset
    rst_n = 1'b0;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready0", 32'(in_ready0), 32'd1);
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_sum0", sum0, 32'd0);
    check("rst_flags0", {29'd0, cout0, ovf0, zero0}, 32'd0);
    check("rst_dbg0", 32'(dbg0), 32'd0);
    check("rst_in_ready1", 32'(in_ready1), 32'd1);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors on 32/8
    for (int i = 0; i < 12; i++) begin
      send0(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), sum0, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), 32'(cout0), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ovf0), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_zero", i), 32'(zero0), 32'(vecs[i].zero));
      drain0();
    end

    // backpressure: result held for 10 cycles, then in_ready one cycle after release
    send0(32'd3, 32'd4, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_sum", sum0, 32'd7);
      check("bp_out_valid", 32'(out_valid0), 32'd1);
      check("bp_in_ready", 32'(in_ready0), 32'd0);
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    check("bp_release_in_ready", 32'(in_ready0), 32'd1);
    check("bp_release_out_valid", 32'(out_valid0), 32'd0);

    // inputs wiggled during RUN must not disturb the op in flight
    check("run_pre_in_ready", 32'(in_ready0), 32'd1);
    a0 = 32'd10; b0 = 32'd20; cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("run_in_ready", 32'(in_ready0), 32'd0);
      in_valid0 = 1'($urandom_range(0, 1));
      a0 = $urandom;
      b0 = $urandom;
      sub0 = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    g = 0;
    while (!out_valid0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("run_ignore_sum", sum0, 32'd30);
    check("run_ignore_cout", 32'(cout0), 32'd0);
    drain0();

    // reset after chunk 2 of an op; previous result leaves cout=1, zero=1 behind
    send0(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
    drain0();
    a0 = 32'h1111_1111; b0 = 32'h2222_2222; cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", sum0, 32'd0);
    check("midrst_flags", {29'd0, cout0, ovf0, zero0}, 32'd0);
    check("midrst_out_valid", 32'(out_valid0), 32'd0);
    check("midrst_in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send0(32'd1, 32'd2, 1'b0, 1'b0, lat);
    check("postrst_latency", 32'(lat), 32'd4);
    check("postrst_sum", sum0, 32'd3);
    drain0();

    // random ops on 32/8 against the reference model
    for (int i = 0; i < 200; i++) begin
      ra = pick();
      rb = pick();
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rcin, rsub, 32, rs, rc, rov, rz);
      send0(ra, rb, rcin, rsub, lat);
      check("rnd0_latency", 32'(lat), 32'd4);
      check("rnd0_sum", sum0, rs);
      check("rnd0_flags", {29'd0, cout0, ovf0, zero0}, {29'd0, rc, rov, rz});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drain0();
    end

    // single-pass 16/16: one cycle from accept to out_valid
    a1 = 16'd1; b1 = 16'd2; cin1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("lat1_out_valid_early", 32'(out_valid1), 32'd0);
    @(negedge clk);
    check("lat1_out_valid", 32'(out_valid1), 32'd1);
    check("lat1_sum", 32'(sum1), 32'd3);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;

    // random stream on 16/16 with consumer stalls
    fork
      begin : drv
        logic [31:0] s;
        logic        c, ov, z;
        int          guard;
        for (int i = 0; i < 1000; i++) begin
          a1 = 16'($urandom);
          b1 = 16'($urandom);
          cin1 = 1'($urandom_range(0, 1));
          sub1 = 1'($urandom_range(0, 1));
          ref_model({16'd0, a1}, {16'd0, b1}, cin1, sub1, 16, s, c, ov, z);
          exp_q.push_back({c, ov, z, s[15:0]});
          in_valid1 = 1'b1;
          guard = 0;
          while (!in_ready1 && guard < 100) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 100) check("dut1_accept_timeout", 32'd0, 32'd1);
          @(negedge clk);
          in_valid1 = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin : mon
        int          got;
        int          cyc;
        logic [18:0] e;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready1 = 1'($urandom_range(0, 1));
          if (out_valid1 && out_ready1) begin
            if (exp_q.size() == 0) begin
              check("dut1_unexpected_result", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("dut1_sum", 32'(sum1), 32'(e[15:0]));
              check("dut1_cout", 32'(cout1), 32'(e[18]));
              check("dut1_ovf", 32'(ovf1), 32'(e[17]));
              check("dut1_zero", 32'(zero1), 32'(e[16]));
            end
            got++;
          end
        end
        if (got < 1000) check("dut1_result_count", 32'(got), 32'd1000);
        out_ready1 = 1'b0;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
